// File: rtl/decode_if.sv
// Fetch-side and issue-side handshake bundle for the decode stage.
// valid/ready: a word moves on a clock edge only when valid and ready are both high; valid never waits on ready.
interface decode_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 4
);
  localparam int INSTR_W = 4 + 3 * REG_AW + DATA_W;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic               alu_en;
  logic               write_en;
  logic               imm_flag;
  logic [2:0]         alu_opcode;
  logic [DATA_W-1:0]  imm_value;
  logic [REG_AW-1:0]  ra_addr;
  logic [REG_AW-1:0]  rb_addr;
  logic [REG_AW-1:0]  write_addr;
  logic [1:0]         branch_kind;
  logic               halted;
  logic               illegal;

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, alu_en, write_en, imm_flag, alu_opcode,
           imm_value, ra_addr, rb_addr, write_addr, branch_kind, halted, illegal
  );

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, alu_en, write_en, imm_flag, alu_opcode,
           imm_value, ra_addr, rb_addr, write_addr, branch_kind, halted, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// One-deep registered instruction decode with RAW scoreboard stalls,
// sticky HALT, flush of the held instruction and branch/jump decoding.
module decode_stage #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 4,
  parameter int WB_LAT = 2
) (
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);
  localparam int INSTR_W = 4 + 3 * REG_AW + DATA_W;

  logic [3:0]        f_op;
  logic [REG_AW-1:0] f_ra, f_rb, f_rd;
  logic [DATA_W-1:0] f_data;

  assign f_op   = bus.instr[INSTR_W-1 -: 4];
  assign f_ra   = bus.instr[DATA_W+3*REG_AW-1 -: REG_AW];
  assign f_rb   = bus.instr[DATA_W+2*REG_AW-1 -: REG_AW];
  assign f_rd   = bus.instr[DATA_W+REG_AW-1 -: REG_AW];
  assign f_data = bus.instr[DATA_W-1:0];

  // Decoded view of the offered word, loaded into the output register on accept
  logic              d_fwd, d_use_rb, d_illegal, d_halt;
  logic              d_alu_en, d_write_en, d_imm_flag;
  logic [2:0]        d_alu_opcode;
  logic [DATA_W-1:0] d_imm;
  logic [REG_AW-1:0] d_ra, d_rb, d_wa;
  logic [1:0]        d_bk;

  always_comb begin
    d_fwd = 1'b1;  d_use_rb = 1'b0;  d_illegal = 1'b0;  d_halt = 1'b0;
    d_alu_en = 1'b0;  d_write_en = 1'b0;  d_imm_flag = 1'b0;
    d_alu_opcode = 3'b000;  d_imm = '0;
    d_ra = '0;  d_rb = '0;  d_wa = '0;  d_bk = 2'b00;
    case (f_op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
        d_alu_en = 1'b1; d_write_en = 1'b1; d_use_rb = 1'b1;
        d_ra = f_ra; d_rb = f_rb; d_wa = f_rd; d_alu_opcode = f_op[2:0];
      end
      4'h5, 4'h6, 4'h7: begin
        d_alu_en = 1'b1; d_write_en = 1'b1;
        d_ra = f_ra; d_wa = f_rd; d_alu_opcode = f_op[2:0];
      end
      4'h8, 4'h9: begin
        d_alu_en = 1'b1; d_write_en = 1'b1; d_imm_flag = 1'b1;
        d_ra = f_ra; d_wa = f_rd; d_imm = f_data; d_alu_opcode = {2'b00, f_op[0]};
      end
      4'hC, 4'hD: begin
        d_alu_en = 1'b1; d_use_rb = 1'b1; d_ra = f_ra; d_rb = f_rb;
        d_alu_opcode = 3'b001; d_imm = f_data; d_bk = f_op[0] ? 2'b10 : 2'b01;
      end
      4'hE: begin
        d_alu_en = 1'b1; d_imm_flag = 1'b1; d_ra = f_ra; d_imm = f_data; d_bk = 2'b11;
      end
      4'hA, 4'hB: begin d_fwd = 1'b0; d_illegal = 1'b1; end
      default:    begin d_fwd = 1'b0; d_halt = 1'b1; end
    endcase
  end

  logic              ov_q, alu_en_q, we_q, imm_flag_q, halted_q, illegal_q;
  logic [2:0]        alu_opcode_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_AW-1:0] ra_q, rb_q, wa_q;
  logic [1:0]        bk_q;
  logic [WB_LAT-1:0] sb_v;
  logic [REG_AW-1:0] sb_a [WB_LAT];

  // A source is busy while its writer is held here or still inside the writeback window
  logic ra_busy, rb_busy, hazard;
  always_comb begin
    ra_busy = ov_q && we_q && (wa_q == f_ra);
    rb_busy = ov_q && we_q && (wa_q == f_rb);
    for (int i = 0; i < WB_LAT; i++) begin
      if (sb_v[i] && sb_a[i] == f_ra) ra_busy = 1'b1;
      if (sb_v[i] && sb_a[i] == f_rb) rb_busy = 1'b1;
    end
  end
  assign hazard = (d_fwd && ra_busy) || (d_use_rb && rb_busy);

  logic accept, issue;
  assign bus.in_ready = rst && !halted_q && !bus.flush && !hazard && (!ov_q || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign issue  = ov_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ov_q <= 1'b0; alu_en_q <= 1'b0; we_q <= 1'b0; imm_flag_q <= 1'b0;
      halted_q <= 1'b0; illegal_q <= 1'b0; alu_opcode_q <= '0; imm_q <= '0;
      ra_q <= '0; rb_q <= '0; wa_q <= '0; bk_q <= '0; sb_v <= '0;
      for (int i = 0; i < WB_LAT; i++) sb_a[i] <= '0;
    end else begin
      // The writeback window slides every cycle, stalled or not
      sb_v[0] <= issue && we_q;
      sb_a[0] <= wa_q;
      for (int i = 1; i < WB_LAT; i++) begin
        sb_v[i] <= sb_v[i-1];
        sb_a[i] <= sb_a[i-1];
      end
      illegal_q <= accept && d_illegal;
      if (accept && d_halt) halted_q <= 1'b1;
      if (bus.flush) begin
        ov_q <= 1'b0;
      end else if (accept) begin
        ov_q <= d_fwd; alu_en_q <= d_alu_en; we_q <= d_write_en; imm_flag_q <= d_imm_flag;
        alu_opcode_q <= d_alu_opcode; imm_q <= d_imm;
        ra_q <= d_ra; rb_q <= d_rb; wa_q <= d_wa; bk_q <= d_bk;
      end else if (issue) begin
        ov_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = ov_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.write_en    = we_q;
  assign bus.imm_flag    = imm_flag_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.imm_value   = imm_q;
  assign bus.ra_addr     = ra_q;
  assign bus.rb_addr     = rb_q;
  assign bus.write_addr  = wa_q;
  assign bus.branch_kind = bk_q;
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: transaction-level reference model with an
// expected-output queue and a time-stamped pending-write list, plus literal checks.
module tb_decode_stage;
  localparam int DATA_W = 8;
  localparam int REG_AW = 4;
  localparam int WB_LAT = 2;

  typedef struct packed {
    logic       alu_en, write_en, imm_flag;
    logic [2:0] opc;
    logic [7:0] imm;
    logic [3:0] ra, rb, wa;
    logic [1:0] bk;
  } dec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  decode_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();
  decode_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .WB_LAT(WB_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  dec_t exp_q[$];
  logic [3:0] pend_a[$];
  int         pend_t[$];
  logic m_halted = 1'b0;
  logic m_illegal = 1'b0;

  function automatic logic fwd_op(input logic [3:0] op);
    return !(op == 4'hA || op == 4'hB || op == 4'hF);
  endfunction

  function automatic dec_t decode(input logic [23:0] w);
    logic [3:0] op;
    dec_t r;
    op = w[23:20];
    r = '0;
    if (op <= 4'h7) begin
      r.alu_en = 1; r.write_en = 1; r.ra = w[19:16]; r.wa = w[11:8]; r.opc = op[2:0];
      if (op <= 4'h4) r.rb = w[15:12];
    end else if (op == 4'h8 || op == 4'h9) begin
      r.alu_en = 1; r.write_en = 1; r.imm_flag = 1; r.ra = w[19:16]; r.wa = w[11:8];
      r.imm = w[7:0]; r.opc = (op == 4'h9) ? 3'd1 : 3'd0;
    end else if (op == 4'hC || op == 4'hD) begin
      r.alu_en = 1; r.ra = w[19:16]; r.rb = w[15:12]; r.opc = 3'd1; r.imm = w[7:0];
      r.bk = (op == 4'hC) ? 2'b01 : 2'b10;
    end else if (op == 4'hE) begin
      r.alu_en = 1; r.imm_flag = 1; r.ra = w[19:16]; r.imm = w[7:0]; r.bk = 2'b11;
    end
    return r;
  endfunction

  function automatic logic blocked(input logic [3:0] a);
    if (exp_q.size() > 0 && exp_q[0].write_en && exp_q[0].wa == a) return 1'b1;
    foreach (pend_a[i]) if (pend_a[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_ready();
    logic [3:0] op;
    logic haz;
    op = bus.instr[23:20];
    haz = (fwd_op(op) && blocked(bus.instr[19:16])) ||
          ((op <= 4'h4 || op == 4'hC || op == 4'hD) && blocked(bus.instr[15:12]));
    return rst && !m_halted && !bus.flush && !haz && (exp_q.size() == 0 || bus.out_ready);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete(); pend_a.delete(); pend_t.delete();
      m_halted = 1'b0; m_illegal = 1'b0;
    end else begin
      logic acc, iss;
      logic [3:0] op;
      acc = bus.in_valid && m_ready();
      iss = exp_q.size() > 0 && bus.out_ready;
      op  = bus.instr[23:20];
      edge_cnt++;
      for (int i = pend_t.size() - 1; i >= 0; i--)
        if (pend_t[i] <= edge_cnt) begin pend_t.delete(i); pend_a.delete(i); end
      if (iss && exp_q[0].write_en) begin
        pend_a.push_back(exp_q[0].wa);
        pend_t.push_back(edge_cnt + WB_LAT);
      end
      if ((iss || bus.flush) && exp_q.size() > 0) void'(exp_q.pop_front());
      m_illegal = acc && (op == 4'hA || op == 4'hB);
      if (acc && op == 4'hF) m_halted = 1'b1;
      if (acc && fwd_op(op)) exp_q.push_back(decode(bus.instr));
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      dec_t h;
      chk("in_ready", bus.in_ready, m_ready());
      chk("out_valid", bus.out_valid, exp_q.size() > 0);
      chk("halted", bus.halted, m_halted);
      chk("illegal", bus.illegal, m_illegal);
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        chk("alu_en", bus.alu_en, h.alu_en);
        chk("write_en", bus.write_en, h.write_en);
        chk("imm_flag", bus.imm_flag, h.imm_flag);
        chk("alu_opcode", bus.alu_opcode, h.opc);
        chk("imm_value", bus.imm_value, h.imm);
        chk("ra_addr", bus.ra_addr, h.ra);
        chk("rb_addr", bus.rb_addr, h.rb);
        chk("write_addr", bus.write_addr, h.wa);
        chk("branch_kind", bus.branch_kind, h.bk);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [23:0] w, output int acc, output int stalls);
    bus.in_valid = 1'b1;
    bus.instr = w;
    stalls = 0;
    while (stalls < 40) begin
      @(negedge clk);
      if (bus.in_ready) break;
      stalls++;
    end
    if (stalls >= 40) begin
      checks++; errors++;
      $display("FAIL accept_timeout instr %06h never accepted", w);
    end
    @(posedge clk); #1;
    acc = edge_cnt;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int e1, e2, s1, s2;
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.instr = 24'h012300; bus.flush = 1'b0; bus.out_ready = 1'b1;
    #3;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_illegal", bus.illegal, 0);
    @(posedge clk); #1 rst = 1'b1;

    // traffic at full rate, then asynchronous reset between edges
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_in_ready", bus.in_ready, 0);
    chk("async_write_en", bus.write_en, 0);
    chk("async_alu_en", bus.alu_en, 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    bus.in_valid = 1'b1;
    #1 chk("release_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b0;

    // ALU decode
    send(24'h012300, e1, s1);
    chk("alu_out_valid", bus.out_valid, 1);
    chk("alu_opcode_lit", bus.alu_opcode, 0);
    chk("alu_ra_lit", bus.ra_addr, 1);
    chk("alu_rb_lit", bus.rb_addr, 2);
    chk("alu_wa_lit", bus.write_addr, 3);
    chk("alu_we_lit", bus.write_en, 1);
    chk("alu_imm_flag_lit", bus.imm_flag, 0);
    chk("alu_bk_lit", bus.branch_kind, 0);
    idle(4);

    // RAW stall back-to-back
    send(24'h012300, e1, s1);
    send(24'h530400, e2, s2);
    chk("raw_accept_gap", e2 - e1, 4);
    chk("raw_stall_cycles", s2, 3);
    idle(4);

    // RAW stall with issue held off two extra cycles
    bus.out_ready = 1'b0;
    send(24'h012300, e1, s1);
    fork
      send(24'h530400, e2, s2);
      begin repeat (2) @(posedge clk); #1 bus.out_ready = 1'b1; end
    join
    chk("raw_hold_gap", e2 - e1, 6);
    chk("raw_hold_stall", s2, 5);
    idle(4);

    // immediate and jump
    send(24'h910555, e1, s1);
    chk("imm_flag_lit", bus.imm_flag, 1);
    chk("imm_opcode_lit", bus.alu_opcode, 1);
    chk("imm_value_lit", bus.imm_value, 8'h55);
    chk("imm_wa_lit", bus.write_addr, 5);
    send(24'hE20010, e1, s1);
    chk("jmp_bk_lit", bus.branch_kind, 2'b11);
    chk("jmp_imm_flag_lit", bus.imm_flag, 1);
    chk("jmp_imm_lit", bus.imm_value, 8'h10);
    chk("jmp_we_lit", bus.write_en, 0);
    idle(4);

    // branch held, then flushed
    bus.out_ready = 1'b0;
    send(24'hC12034, e1, s1);
    chk("br_bk_lit", bus.branch_kind, 2'b01);
    chk("br_opcode_lit", bus.alu_opcode, 1);
    chk("br_ra_lit", bus.ra_addr, 1);
    chk("br_rb_lit", bus.rb_addr, 2);
    chk("br_imm_lit", bus.imm_value, 8'h34);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.instr = 24'h400000;
    #1 chk("flush_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_out_valid", bus.out_valid, 0);

    // flush coinciding with issue still records the write
    send(24'h012300, e1, s1);
    bus.out_ready = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    chk("flush_issue_out_valid", bus.out_valid, 0);
    send(24'h530400, e2, s2);
    chk("flush_issue_stall", s2, 2);
    idle(4);

    // reserved opcode
    send(24'hA00000, e1, s1);
    chk("illegal_pulse", bus.illegal, 1);
    chk("illegal_no_valid", bus.out_valid, 0);
    idle(1);
    chk("illegal_one_cycle", bus.illegal, 0);

    // HALT: held write drains, then everything blocks until reset
    send(24'h012300, e1, s1);
    send(24'hF00000, e2, s2);
    chk("halt_rise", bus.halted, 1);
    chk("halt_no_valid", bus.out_valid, 0);
    bus.in_valid = 1'b1; bus.instr = 24'h400000;
    idle(4);
    chk("halt_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1 chk("halt_cleared", bus.halted, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
